sd_cmd_engine: RTL and testbench

Command/response sequencer for the SPI-mode SD controller. It takes one command request (index, argument, expected response length) from the SD controller FSM and builds the 48-bit command frame with CRC7. It drives the frame byte-by-byte into the SPI byte master, polls for the response start byte, collects 1–5 response bytes, and returns them with a timeout flag. It is the engine behind the controller's WaitSendCmd/WaitReceiveCmd states. Chip-select, data-block tokens and clock-rate switching stay in the controller.

---
 rtl/sd_controller_pkg.sv | 44 ++++
 rtl/sd_crc7.sv | 21 ++
 rtl/sd_cmd_engine.sv | 157 +++++++++++++++
 tb/tb_sd_cmd_engine.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_controller_pkg.sv
// Shared types and constants for the SPI-mode SD controller and its command engine.
package sd_controller_pkg;

  typedef logic [5:0]  cmd_index_t;
  typedef logic [31:0] cmd_argument_t;

  localparam cmd_index_t Cmd0   = 6'd0;
  localparam cmd_index_t Cmd8   = 6'd8;
  localparam cmd_index_t Cmd13  = 6'd13;
  localparam cmd_index_t Acmd41 = 6'd41;
  localparam cmd_index_t Cmd55  = 6'd55;

  localparam cmd_argument_t NullCmdArgument = 32'h0000_0000;
  localparam cmd_argument_t Cmd8Argument    = 32'h0000_01AA;
  localparam cmd_argument_t Acmd41Argument  = 32'h4000_0000;

  localparam logic [39:0] Cmd8Response  = 40'h01_0000_01AA;
  localparam logic [39:0] Cmd13Response = 40'h00_0000_0000;

  typedef enum logic [2:0] {
    Idle,
    SendFrame,
    PollResp,
    ReadResp,
    Done
  } sd_cmd_engine_fsm_t;

  localparam logic [1:0] CmdStartBits     = 2'b01;
  localparam logic [6:0] Crc7Polynomial   = 7'h09;
  localparam logic [7:0] SpiIdleByte      = 8'hFF;
  localparam int         MaxResponseBytes = 5;

  // A zero length still waits for the R1 byte; anything longer than R7 is capped.
  function automatic logic [2:0] clamp_response_bytes(input logic [2:0] requested);
    if (requested == 3'd0) begin
      return 3'd1;
    end else if (requested > 3'(MaxResponseBytes)) begin
      return 3'(MaxResponseBytes);
    end else begin
      return requested;
    end
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Combinational CRC7 (x^7 + x^3 + 1, zero seed, MSB first) over a 40-bit message.
module sd_crc7
  import sd_controller_pkg::*;
(
  input  logic [39:0] data,
  output logic [6:0]  crc
);

  // Bit-serial LFSR unrolled across all 40 message bits.
  always_comb begin
    crc = '0;
    for (int i = 39; i >= 0; i--) begin
      if (crc[6] ^ data[i]) begin
        crc = {crc[5:0], 1'b0} ^ Crc7Polynomial;
      end else begin
        crc = {crc[5:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD command/response sequencer: frames a command with CRC7, pushes it through the
// SPI byte master one byte at a time, polls for the R1 start byte and gathers the response.
module sd_cmd_engine
  import sd_controller_pkg::*;
#(
  parameter int MaxPollBytes = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  cmd_index_t    cmd_index,
  input  cmd_argument_t cmd_argument,
  input  logic [2:0]    response_bytes,
  output logic [39:0]   response,
  output logic          resp_valid,
  output logic          timeout,
  output logic          busy,
  output logic [7:0]    spi_tx_data,
  output logic          spi_tx_valid,
  input  logic          spi_tx_ready,
  input  logic [7:0]    spi_rx_data,
  input  logic          spi_rx_valid
);

  localparam logic [7:0] PollLast = 8'(MaxPollBytes - 1);

  sd_cmd_engine_fsm_t state;
  logic [39:0] frame_rest;
  logic [2:0]  byte_cnt;
  logic [7:0]  poll_cnt;
  logic [2:0]  resp_cnt;
  logic [2:0]  resp_len;
  logic        awaiting_rx;
  logic [6:0]  crc_out;
  logic        rx_take;

  // CRC is computed straight from the request inputs so it is ready at accept time.
  sd_crc7 u_crc7 (
    .data ({CmdStartBits, cmd_index, cmd_argument}),
    .crc  (crc_out)
  );

  assign rx_take = awaiting_rx && spi_rx_valid;

  // Command sequencer: one outstanding SPI byte at a time, every output registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= Idle;
      cmd_ready    <= 1'b1;
      response     <= '0;
      resp_valid   <= 1'b0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
      spi_tx_valid <= 1'b0;
      spi_tx_data  <= SpiIdleByte;
      frame_rest   <= '0;
      byte_cnt     <= '0;
      poll_cnt     <= '0;
      resp_cnt     <= '0;
      resp_len     <= 3'd1;
      awaiting_rx  <= 1'b0;
    end else begin
      if (spi_tx_valid && spi_tx_ready) begin
        spi_tx_valid <= 1'b0;
        awaiting_rx  <= 1'b1;
      end
      if (rx_take) begin
        awaiting_rx <= 1'b0;
      end

      case (state)
        Idle: begin
          if (cmd_valid) begin
            state        <= SendFrame;
            cmd_ready    <= 1'b0;
            busy         <= 1'b1;
            response     <= '0;
            timeout      <= 1'b0;
            resp_len     <= clamp_response_bytes(response_bytes);
            frame_rest   <= {cmd_argument, crc_out, 1'b1};
            byte_cnt     <= '0;
            poll_cnt     <= '0;
            resp_cnt     <= '0;
            spi_tx_data  <= {CmdStartBits, cmd_index};
            spi_tx_valid <= 1'b1;
          end
        end

        SendFrame: begin
          if (rx_take) begin
            spi_tx_valid <= 1'b1;
            if (byte_cnt == 3'd5) begin
              state       <= PollResp;
              spi_tx_data <= SpiIdleByte;
            end else begin
              spi_tx_data <= frame_rest[39:32];
              frame_rest  <= {frame_rest[31:0], 8'h00};
              byte_cnt    <= byte_cnt + 3'd1;
            end
          end
        end

        PollResp: begin
          if (rx_take) begin
            if (!spi_rx_data[7]) begin
              response <= {response[31:0], spi_rx_data};
              resp_cnt <= 3'd1;
              if (resp_len == 3'd1) begin
                state      <= Done;
                resp_valid <= 1'b1;
              end else begin
                state        <= ReadResp;
                spi_tx_data  <= SpiIdleByte;
                spi_tx_valid <= 1'b1;
              end
            end else if (poll_cnt == PollLast) begin
              timeout    <= 1'b1;
              state      <= Done;
              resp_valid <= 1'b1;
            end else begin
              poll_cnt     <= poll_cnt + 8'd1;
              spi_tx_data  <= SpiIdleByte;
              spi_tx_valid <= 1'b1;
            end
          end
        end

        ReadResp: begin
          if (rx_take) begin
            response <= {response[31:0], spi_rx_data};
            if (resp_cnt + 3'd1 == resp_len) begin
              state      <= Done;
              resp_valid <= 1'b1;
            end else begin
              resp_cnt     <= resp_cnt + 3'd1;
              spi_tx_data  <= SpiIdleByte;
              spi_tx_valid <= 1'b1;
            end
          end
        end

        Done: begin
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          cmd_ready  <= 1'b1;
          state      <= Idle;
        end

        default: begin
          state <= Idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Self-checking bench for sd_cmd_engine with a behavioural SPI byte master and a stream-level model.
module tb_sd_cmd_engine;
  import sd_controller_pkg::*;

  localparam int MaxPoll = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_argument;
  logic [2:0]  response_bytes;
  logic [39:0] response;
  logic        resp_valid;
  logic        timeout;
  logic        busy;
  logic [7:0]  spi_tx_data;
  logic        spi_tx_valid;
  logic        spi_tx_ready;
  logic [7:0]  spi_rx_data;
  logic        spi_rx_valid;

  int errors = 0;
  int checks = 0;

  // Written by the test sequence, read by the SPI responder.
  logic [7:0] rx_script [0:255];
  int         script_base = 0;
  int         script_len = 0;
  int         stall_req = 0;
  bit         random_ready = 1'b0;

  // Written by the SPI responder only.
  logic [7:0] tx_log [0:255];
  int         tx_total = 0;
  int         stall_served = 0;
  int         rx_countdown = 0;
  logic [7:0] rx_pending = 8'hFF;

  // Reference model outputs.
  logic [7:0]  exp_tx [0:63];
  int          exp_n;
  logic [39:0] exp_resp;
  logic        exp_to;

  always #5 clock = ~clock;

  sd_cmd_engine #(.MaxPollBytes(MaxPoll)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_index      (cmd_index),
    .cmd_argument   (cmd_argument),
    .response_bytes (response_bytes),
    .response       (response),
    .resp_valid     (resp_valid),
    .timeout        (timeout),
    .busy           (busy),
    .spi_tx_data    (spi_tx_data),
    .spi_tx_valid   (spi_tx_valid),
    .spi_tx_ready   (spi_tx_ready),
    .spi_rx_data    (spi_rx_data),
    .spi_rx_valid   (spi_rx_valid)
  );

  // SPI byte master model: logs each accepted byte and answers it from the script after a delay.
  initial begin
    spi_tx_ready = 1'b0;
    spi_rx_valid = 1'b0;
    spi_rx_data  = 8'h00;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        spi_rx_valid = 1'b0;
        spi_tx_ready = 1'b0;
        rx_countdown = 0;
        stall_served = stall_req;
      end else begin
        spi_rx_valid = 1'b0;
        if (rx_countdown > 0) begin
          rx_countdown = rx_countdown - 1;
          if (rx_countdown == 0) begin
            spi_rx_valid = 1'b1;
            spi_rx_data  = rx_pending;
          end
        end
        if (stall_served < stall_req) begin
          spi_tx_ready = 1'b0;
          stall_served = stall_served + 1;
        end else if (random_ready) begin
          spi_tx_ready = ($urandom_range(0, 2) != 0);
        end else begin
          spi_tx_ready = 1'b1;
        end
        if (spi_tx_ready && spi_tx_valid) begin
          tx_log[tx_total % 256] = spi_tx_data;
          if ((tx_total - script_base) < script_len)
            rx_pending = rx_script[tx_total - script_base];
          else
            rx_pending = 8'hFF;
          tx_total = tx_total + 1;
          rx_countdown = random_ready ? int'($urandom_range(1, 3)) : 1;
        end
      end
    end
  end

  function automatic logic [7:0] script_byte(input int i);
    return (i < script_len) ? rx_script[i] : 8'hFF;
  endfunction

  // CRC7 as the remainder of msg * x^7 divided by x^7 + x^3 + 1.
  function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
    logic [46:0] rem;
    rem = {msg, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (rem[i]) rem[i -: 8] = rem[i -: 8] ^ 8'h89;
    end
    return rem[6:0];
  endfunction

  // Expected SPI byte stream, response and timeout for the current script.
  task automatic model_command(input logic [5:0] idx, input logic [31:0] arg, input logic [2:0] rb);
    int len;
    logic [6:0] c;
    logic [7:0] b;
    bit found;
    len = (rb == 0) ? 1 : ((rb > 5) ? 5 : int'(rb));
    c = ref_crc7({2'b01, idx, arg});
    exp_tx[0] = {2'b01, idx};
    exp_tx[1] = arg[31:24];
    exp_tx[2] = arg[23:16];
    exp_tx[3] = arg[15:8];
    exp_tx[4] = arg[7:0];
    exp_tx[5] = {c, 1'b1};
    exp_n = 6;
    exp_resp = '0;
    exp_to = 1'b1;
    found = 1'b0;
    for (int p = 0; p < MaxPoll; p++) begin
      if (!found) begin
        b = script_byte(6 + p);
        exp_tx[exp_n] = 8'hFF;
        exp_n++;
        if (!b[7]) begin
          found = 1'b1;
          exp_to = 1'b0;
          exp_resp = {32'b0, b};
          for (int k = 1; k < len; k++) begin
            exp_tx[exp_n] = 8'hFF;
            exp_n++;
            exp_resp = {exp_resp[31:0], script_byte(6 + p + k)};
          end
        end
      end
    end
  endtask

  function automatic int tx_diff();
    int d;
    d = 0;
    if ((tx_total - script_base) != exp_n) d++;
    for (int i = 0; i < exp_n; i++) begin
      if (tx_log[(script_base + i) % 256] !== exp_tx[i]) d++;
    end
    return d;
  endfunction

  function automatic logic [7:0] tx_at(input int i);
    return tx_log[(script_base + i) % 256];
  endfunction

  // Start a fresh script: six discarded frame-time bytes first, then the reply stream.
  task automatic new_script();
    script_base = tx_total;
    script_len = 6;
    for (int i = 0; i < 6; i++) rx_script[i] = 8'($urandom);
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_script[script_len] = b;
    script_len++;
  endtask

  // Issue one command and observe it to completion.
  task automatic run_command(input logic [5:0] idx, input logic [31:0] arg, input logic [2:0] rb,
                             output logic [39:0] resp, output logic to, output int pulses,
                             output int overlap, output logic first_ok, output logic done_ok);
    int n;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_index = idx;
    cmd_argument = arg;
    response_bytes = rb;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #1;
    first_ok = (spi_tx_valid === 1'b1 && spi_tx_data === {2'b01, idx} &&
                cmd_ready === 1'b0 && busy === 1'b1);
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_index = 6'($urandom);
    cmd_argument = $urandom;
    response_bytes = 3'($urandom);
    pulses = 0;
    overlap = 0;
    done_ok = 1'b0;
    resp = '0;
    to = 1'b0;
    for (int c = 0; c < 3000 && !done_ok; c++) begin
      @(posedge clock);
      #1;
      if (resp_valid === 1'b1) begin
        pulses++;
        resp = response;
        to = timeout;
        if (busy !== 1'b1) overlap++;
      end
      if (cmd_ready === 1'b1 && busy === 1'b1) overlap++;
      if (cmd_ready === 1'b1) done_ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    cmd_valid = 1'b0;
    cmd_index = '0;
    cmd_argument = '0;
    response_bytes = 3'd1;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    checks++; if (response !== 40'h0) begin errors++; $display("[TB] FAIL reset_response: got %h expected 0", response); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (spi_tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", spi_tx_valid); end
    checks++; if (spi_tx_data !== 8'hFF) begin errors++; $display("[TB] FAIL reset_tx_data: got %h expected ff", spi_tx_data); end
  endtask

  task automatic test_cmd0();
    logic [39:0] r; logic t, f, d; int p, o;
    new_script();
    push_rx(8'hFF); push_rx(8'hFF); push_rx(8'h01);
    model_command(Cmd0, NullCmdArgument, 3'd1);
    run_command(Cmd0, NullCmdArgument, 3'd1, r, t, p, o, f, d);
    checks++; if (f !== 1'b1) begin errors++; $display("[TB] FAIL cmd0_first_byte: got %b expected 1", f); end
    checks++; if (d !== 1'b1) begin errors++; $display("[TB] FAIL cmd0_done: got %b expected 1", d); end
    checks++; if (p != 1) begin errors++; $display("[TB] FAIL cmd0_pulse: got %0d expected 1", p); end
    checks++; if (o != 0) begin errors++; $display("[TB] FAIL cmd0_ready_busy: got %0d expected 0", o); end
    checks++; if ((tx_total - script_base) != 9) begin errors++; $display("[TB] FAIL cmd0_tx_count: got %0d expected 9", tx_total - script_base); end
    checks++; if (tx_at(5) !== 8'h95) begin errors++; $display("[TB] FAIL cmd0_crc: got %h expected 95", tx_at(5)); end
    checks++; if (tx_diff() != 0) begin errors++; $display("[TB] FAIL cmd0_tx_stream: got %0d bad bytes expected 0", tx_diff()); end
    checks++; if (r !== 40'h01) begin errors++; $display("[TB] FAIL cmd0_resp: got %h expected 01", r); end
    checks++; if (t !== 1'b0) begin errors++; $display("[TB] FAIL cmd0_timeout: got %b expected 0", t); end
  endtask

  task automatic test_cmd8();
    logic [39:0] r; logic t, f, d; int p, o;
    new_script();
    push_rx(8'hFF); push_rx(8'h01); push_rx(8'h00); push_rx(8'h00); push_rx(8'h01); push_rx(8'hAA);
    model_command(Cmd8, Cmd8Argument, 3'd5);
    run_command(Cmd8, Cmd8Argument, 3'd5, r, t, p, o, f, d);
    checks++; if (f !== 1'b1 || d !== 1'b1 || p != 1) begin errors++; $display("[TB] FAIL cmd8_handshake: got first=%b done=%b pulses=%0d expected 1 1 1", f, d, p); end
    checks++; if (tx_at(5) !== 8'h87) begin errors++; $display("[TB] FAIL cmd8_crc: got %h expected 87", tx_at(5)); end
    checks++; if (tx_diff() != 0) begin errors++; $display("[TB] FAIL cmd8_tx_stream: got %0d bad bytes expected 0", tx_diff()); end
    checks++; if (r !== 40'h01000001AA) begin errors++; $display("[TB] FAIL cmd8_resp: got %h expected 01000001aa", r); end
    checks++; if (t !== 1'b0) begin errors++; $display("[TB] FAIL cmd8_timeout: got %b expected 0", t); end
  endtask

  task automatic test_acmd41();
    logic [39:0] r; logic t, f, d; int p, o;
    new_script();
    push_rx(8'h01);
    model_command(Cmd55, NullCmdArgument, 3'd1);
    run_command(Cmd55, NullCmdArgument, 3'd1, r, t, p, o, f, d);
    checks++; if (tx_at(5) !== 8'h65) begin errors++; $display("[TB] FAIL cmd55_crc: got %h expected 65", tx_at(5)); end
    checks++; if (r !== 40'h01 || t !== 1'b0) begin errors++; $display("[TB] FAIL cmd55_resp: got %h/%b expected 01/0", r, t); end
    checks++; if (o != 0 || f !== 1'b1) begin errors++; $display("[TB] FAIL cmd55_ready_low: got overlap=%0d first=%b expected 0 1", o, f); end
    new_script();
    push_rx(8'hFF); push_rx(8'h00);
    model_command(Acmd41, Acmd41Argument, 3'd1);
    run_command(Acmd41, Acmd41Argument, 3'd1, r, t, p, o, f, d);
    checks++; if (tx_at(5) !== 8'h77) begin errors++; $display("[TB] FAIL acmd41_crc: got %h expected 77", tx_at(5)); end
    checks++; if (tx_diff() != 0) begin errors++; $display("[TB] FAIL acmd41_tx_stream: got %0d bad bytes expected 0", tx_diff()); end
    checks++; if (r !== 40'h00 || t !== 1'b0 || p != 1) begin errors++; $display("[TB] FAIL acmd41_resp: got %h/%b/%0d expected 00/0/1", r, t, p); end
    checks++; if (o != 0 || d !== 1'b1) begin errors++; $display("[TB] FAIL acmd41_ready_low: got overlap=%0d done=%b expected 0 1", o, d); end
  endtask

  task automatic test_cmd13_stall();
    logic [39:0] r; logic t, f, d; int p, o;
    new_script();
    push_rx(8'h00); push_rx(8'h00);
    model_command(Cmd13, NullCmdArgument, 3'd2);
    fork
      run_command(Cmd13, NullCmdArgument, 3'd2, r, t, p, o, f, d);
      begin : stall_probe
        int w;
        logic [7:0] held;
        w = 0;
        while (!((tx_total - script_base) == 3 && spi_tx_valid === 1'b1) && w < 300) begin
          @(posedge clock);
          #1;
          w++;
        end
        checks++;
        if (w >= 300) begin
          errors++;
          $display("[TB] FAIL cmd13_stall_reach: got no byte 3 within %0d cycles expected byte 3", w);
        end else begin
          stall_req = stall_req + 3;
          held = spi_tx_data;
          for (int k = 0; k < 3; k++) begin
            checks++;
            if (spi_tx_valid !== 1'b1 || held !== exp_tx[3]) begin
              errors++;
              $display("[TB] FAIL cmd13_stall_hold%0d: got valid=%b data=%h expected 1 %h", k, spi_tx_valid, spi_tx_data, exp_tx[3]);
            end
            @(posedge clock);
            #1;
            held = spi_tx_data;
          end
        end
      end
    join
    checks++; if (tx_diff() != 0) begin errors++; $display("[TB] FAIL cmd13_tx_stream: got %0d bad bytes expected 0", tx_diff()); end
    checks++; if (r !== 40'h0000 || t !== 1'b0 || p != 1 || d !== 1'b1) begin errors++; $display("[TB] FAIL cmd13_resp: got %h/%b/%0d expected 0000/0/1", r, t, p); end
  endtask

  task automatic test_timeout();
    logic [39:0] r; logic t, f, d; int p, o;
    new_script();
    model_command(Cmd0, NullCmdArgument, 3'd1);
    run_command(Cmd0, NullCmdArgument, 3'd1, r, t, p, o, f, d);
    checks++; if ((tx_total - script_base) != 6 + MaxPoll) begin errors++; $display("[TB] FAIL timeout_tx_count: got %0d expected %0d", tx_total - script_base, 6 + MaxPoll); end
    checks++; if (t !== 1'b1 || p != 1) begin errors++; $display("[TB] FAIL timeout_flag: got %b/%0d expected 1/1", t, p); end
    checks++; if (r !== 40'h0) begin errors++; $display("[TB] FAIL timeout_resp: got %h expected 0", r); end
    random_ready = 1'b1;
    new_script();
    for (int i = 0; i < MaxPoll + 4; i++) push_rx(8'($urandom) | 8'h80);
    model_command(Cmd8, Cmd8Argument, 3'd5);
    run_command(Cmd8, Cmd8Argument, 3'd5, r, t, p, o, f, d);
    checks++; if (tx_diff() != 0 || t !== 1'b1 || r !== 40'h0) begin errors++; $display("[TB] FAIL timeout_random: got bad=%0d to=%b resp=%h expected 0 1 0", tx_diff(), t, r); end
    random_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [39:0] r; logic t, f, d; int p, o;
    logic [5:0] idx; logic [31:0] arg; logic [2:0] rb; int polls;
    random_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      idx = 6'($urandom);
      arg = $urandom;
      rb = 3'($urandom_range(0, 7));
      polls = $urandom_range(0, MaxPoll);
      new_script();
      for (int i = 0; i < polls; i++) push_rx(8'($urandom) | 8'h80);
      push_rx(8'($urandom) & 8'h7F);
      for (int i = 0; i < 4; i++) push_rx(8'($urandom));
      model_command(idx, arg, rb);
      run_command(idx, arg, rb, r, t, p, o, f, d);
      checks++;
      if (r !== exp_resp || t !== exp_to || tx_diff() != 0 || p != 1 || o != 0 || f !== 1'b1 || d !== 1'b1) begin
        errors++;
        $display("[TB] FAIL random%0d: got resp=%h to=%b bad=%0d pulses=%0d expected resp=%h to=%b bad=0 pulses=1",
                 n, r, t, tx_diff(), p, exp_resp, exp_to);
      end
    end
    random_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [39:0] r; logic t, f, d; int p, o; int w;
    new_script();
    push_rx(8'h01);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_index = Cmd0;
    cmd_argument = NullCmdArgument;
    response_bytes = 3'd1;
    @(negedge clock);
    cmd_valid = 1'b0;
    w = 0;
    while (!((tx_total - script_base) == 3 && spi_tx_valid === 1'b1) && w < 300) begin
      @(posedge clock);
      #1;
      w++;
    end
    checks++; if (w >= 300) begin errors++; $display("[TB] FAIL midreset_reach: got no byte 3 within %0d cycles expected byte 3", w); end
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || response !== 40'h0 || resp_valid !== 1'b0 || timeout !== 1'b0 ||
        busy !== 1'b0 || spi_tx_valid !== 1'b0 || spi_tx_data !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL midreset_values: got ready=%b resp=%h rv=%b to=%b busy=%b txv=%b txd=%h expected 1 0 0 0 0 0 ff",
               cmd_ready, response, resp_valid, timeout, busy, spi_tx_valid, spi_tx_data);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    new_script();
    push_rx(8'hFF); push_rx(8'h01);
    model_command(Cmd0, NullCmdArgument, 3'd1);
    run_command(Cmd0, NullCmdArgument, 3'd1, r, t, p, o, f, d);
    checks++; if (tx_diff() != 0) begin errors++; $display("[TB] FAIL midreset_tx_stream: got %0d bad bytes expected 0", tx_diff()); end
    checks++; if (r !== 40'h01 || t !== 1'b0 || p != 1 || d !== 1'b1) begin errors++; $display("[TB] FAIL midreset_resp: got %h/%b/%0d expected 01/0/1", r, t, p); end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8();
    test_acmd41();
    test_cmd13_stall();
    test_timeout();
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
